// File: rtl/store_lane_if.sv
// Store request / memory-bus bundle between the M stage and the store lane aligner.
// slave  : the aligner (accepts requests, drives bus beats and error reporting).
// master : the requester / bus model (drives requests and bus_ready).
// Request side : req_valid, req_ready, req_addr, req_size, req_wdata.
// Bus side     : bus_valid, bus_ready, bus_addr, bus_be, bus_wdata, bus_last.
// Error side   : misalign_err, err_addr.
interface store_lane_if #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [1:0]            req_size;
  logic [8*NBYTES-1:0]   req_wdata;

  logic                  bus_valid;
  logic                  bus_ready;
  logic [ADDR_W-1:0]     bus_addr;
  logic [NBYTES-1:0]     bus_be;
  logic [8*NBYTES-1:0]   bus_wdata;
  logic                  bus_last;

  logic                  misalign_err;
  logic [ADDR_W-1:0]     err_addr;

  modport slave (
    input  req_valid, req_addr, req_size, req_wdata, bus_ready,
    output req_ready, bus_valid, bus_addr, bus_be, bus_wdata, bus_last,
           misalign_err, err_addr
  );

  modport master (
    output req_valid, req_addr, req_size, req_wdata, bus_ready,
    input  req_ready, bus_valid, bus_addr, bus_be, bus_wdata, bus_last,
           misalign_err, err_addr
  );
endinterface

// File: rtl/store_lane_aligner.sv
// Store lane aligner: turns right-justified store requests into registered
// memory-bus beats (aligned address, byte enables, lane-shifted data).
// Misaligned stores that cross a bus word are split into two beats when
// SPLIT_EN=1; with SPLIT_EN=0 every misaligned store is rejected with a
// one-cycle misalign_err pulse and its address captured in err_addr.
// Ports: clk, rst_n (async active-low), sif (store_lane_if.slave).
module store_lane_aligner #(
  parameter int unsigned NBYTES   = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  store_lane_if.slave  sif
);

  localparam int unsigned DW = 8 * NBYTES;
  localparam int unsigned OW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [NBYTES-1:0]   bus_be_q, bus_be_d;
  logic [DW-1:0]       bus_wdata_q, bus_wdata_d;
  logic                bus_last_q, bus_last_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [ADDR_W-1:0]   b2_addr_q, b2_addr_d;
  logic [NBYTES-1:0]   b2_be_q, b2_be_d;
  logic [DW-1:0]       b2_wdata_q, b2_wdata_d;

  logic [OW-1:0]       off_c;
  logic [OW-1:0]       low_mask_c;
  logic [NBYTES-1:0]   size_be_c;
  logic [DW-1:0]       data_m_c;
  logic [2*NBYTES-1:0] wide_be_c;
  logic [2*DW-1:0]     wide_data_c;
  logic                misalign_c;
  logic                cross_c;
  logic                legal_c;
  logic [ADDR_W-1:0]   base_addr_c;
  logic                req_ready_c;
  logic                accept_c;
  logic                hs_c;

  // Request decode: lanes are placed in a double-width window so the upper
  // half directly becomes the second beat of a crossing store.
  always_comb begin
    off_c = sif.req_addr[OW-1:0];
    case (sif.req_size)
      2'b00: begin
        size_be_c  = '1;
        low_mask_c = OW'(NBYTES - 1);
      end
      2'b01: begin
        size_be_c  = NBYTES'(4'hF);
        low_mask_c = OW'(3);
      end
      2'b10: begin
        size_be_c  = NBYTES'(2'h3);
        low_mask_c = OW'(1);
      end
      default: begin
        size_be_c  = NBYTES'(1'b1);
        low_mask_c = '0;
      end
    endcase
    data_m_c = '0;
    for (int i = 0; i < NBYTES; i++) begin
      data_m_c[8*i +: 8] = size_be_c[i] ? sif.req_wdata[8*i +: 8] : 8'h00;
    end
    wide_be_c   = {NBYTES'(0), size_be_c} << off_c;
    wide_data_c = {DW'(0), data_m_c} << {off_c, 3'b000};
    misalign_c  = |(off_c & low_mask_c);
    cross_c     = |wide_be_c[2*NBYTES-1:NBYTES];
    legal_c     = SPLIT_EN || !misalign_c;
    base_addr_c = {sif.req_addr[ADDR_W-1:OW], OW'(0)};
  end

  // A new request may only enter when nothing is held or the final beat of the
  // held request retires this cycle; BEAT2 never accepts.
  always_comb begin
    req_ready_c = (state_q == S_IDLE) ||
                  ((state_q == S_BEAT1) && sif.bus_ready && bus_last_q);
    accept_c    = sif.req_valid && req_ready_c;
    hs_c        = bus_valid_q && sif.bus_ready;
  end

  // Next-state and beat payload.
  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    bus_last_d  = bus_last_q;
    err_d       = 1'b0;
    err_addr_d  = err_addr_q;
    b2_addr_d   = b2_addr_q;
    b2_be_d     = b2_be_q;
    b2_wdata_d  = b2_wdata_q;

    case (state_q)
      S_BEAT1: begin
        if (hs_c) begin
          if (bus_last_q) begin
            state_d     = S_IDLE;
            bus_valid_d = 1'b0;
            bus_addr_d  = '0;
            bus_be_d    = '0;
            bus_wdata_d = '0;
            bus_last_d  = 1'b0;
          end else begin
            state_d     = S_BEAT2;
            bus_addr_d  = b2_addr_q;
            bus_be_d    = b2_be_q;
            bus_wdata_d = b2_wdata_q;
            bus_last_d  = 1'b1;
          end
        end
      end
      S_BEAT2: begin
        if (hs_c) begin
          state_d     = S_IDLE;
          bus_valid_d = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          bus_last_d  = 1'b0;
        end
      end
      default: ;
    endcase

    // Acceptance overrides the retirement above so a new beat follows with no bubble.
    if (accept_c) begin
      if (legal_c) begin
        state_d     = S_BEAT1;
        bus_valid_d = 1'b1;
        bus_addr_d  = base_addr_c;
        bus_be_d    = wide_be_c[NBYTES-1:0];
        bus_wdata_d = wide_data_c[DW-1:0];
        bus_last_d  = !cross_c;
        b2_addr_d   = base_addr_c + ADDR_W'(NBYTES);
        b2_be_d     = wide_be_c[2*NBYTES-1:NBYTES];
        b2_wdata_d  = wide_data_c[2*DW-1:DW];
      end else begin
        err_d       = 1'b1;
        err_addr_d  = sif.req_addr;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      bus_last_q  <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      b2_addr_q   <= '0;
      b2_be_q     <= '0;
      b2_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      bus_last_q  <= bus_last_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      b2_addr_q   <= b2_addr_d;
      b2_be_q     <= b2_be_d;
      b2_wdata_q  <= b2_wdata_d;
    end
  end

  assign sif.req_ready    = req_ready_c;
  assign sif.bus_valid    = bus_valid_q;
  assign sif.bus_addr     = bus_addr_q;
  assign sif.bus_be       = bus_be_q;
  assign sif.bus_wdata    = bus_wdata_q;
  assign sif.bus_last     = bus_last_q;
  assign sif.misalign_err = err_q;
  assign sif.err_addr     = err_addr_q;

endmodule
